// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch front-panel controller.
// Event arbitration lives here so every user sees the same priority order.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_e;

  // One debounced press pulse per button.
  typedef struct packed {
    logic clear;
    logic start;
    logic lap;
    logic dir;
  } btn_evt_t;

  localparam logic [15:0] BCD_ZERO = 16'h0000;
  localparam logic [15:0] BCD_MAX  = 16'h9999;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int DB_W_DEFAULT            = 20;

  // Keep only the highest-priority event: clear > start > lap > dir.
  function automatic btn_evt_t prioritise(btn_evt_t raw);
    btn_evt_t sel;
    sel = '0;
    if (raw.clear) begin
      sel.clear = 1'b1;
    end else if (raw.start) begin
      sel.start = 1'b1;
    end else if (raw.lap) begin
      sel.lap = 1'b1;
    end else if (raw.dir) begin
      sel.dir = 1'b1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge event pulse
// for one raw push-button.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic event_o
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic            level_d;
  logic            event_q;
  logic            event_d;
  logic [DB_W-1:0] cnt_q;
  logic [DB_W-1:0] cnt_d;

  // The counter only runs while the synced input disagrees with the accepted
  // level; any return to agreement (a bounce) restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    event_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        event_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      event_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      event_q <= event_d;
      cnt_q   <= cnt_d;
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Front-panel controller: debounced buttons drive the IDLE/RUN/PAUSE/DONE
// machine, the stopwatch enable/direction/reset and a lap-freeze display.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int DB_W            = DB_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_dir,
  input  logic        btn_lap,
  input  logic [15:0] sw_digits,
  output logic        sw_enable,
  output logic        sw_up,
  output logic        sw_reset,
  output logic [15:0] disp_digits,
  output logic        running,
  output logic        done,
  output logic        lap_active
);

  btn_evt_t  evt_raw;
  btn_evt_t  evt;
  sw_state_e state_q;
  sw_state_e state_d;
  logic        sw_up_q;
  logic        sw_up_d;
  logic        lap_active_q;
  logic        lap_active_d;
  logic [15:0] lap_q;
  logic [15:0] lap_d;
  logic        sw_reset_q;
  logic        sw_reset_d;
  logic        limit;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_start (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (btn_start),
    .event_o (evt_raw.start)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_clear (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (btn_clear),
    .event_o (evt_raw.clear)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_dir (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (btn_dir),
    .event_o (evt_raw.dir)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_db_lap (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_i   (btn_lap),
    .event_o (evt_raw.lap)
  );

  always_comb begin
    evt = prioritise(evt_raw);
  end

  // Limit is seen combinationally so the count stops before it can wrap.
  always_comb begin
    limit = (sw_up_q && (sw_digits == BCD_MAX)) ||
            (!sw_up_q && (sw_digits == BCD_ZERO));
  end

  always_comb begin
    state_d      = state_q;
    sw_up_d      = sw_up_q;
    lap_active_d = lap_active_q;
    lap_d        = lap_q;
    sw_reset_d   = 1'b0;
    if (evt.clear) begin
      state_d      = IDLE;
      lap_active_d = 1'b0;
      sw_reset_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (evt.start) begin
            if (limit) begin
              state_d      = DONE;
              lap_active_d = 1'b0;
            end else begin
              state_d = RUN;
            end
          end else if (evt.dir) begin
            sw_up_d = ~sw_up_q;
          end
        end
        RUN: begin
          if (evt.start) begin
            state_d = PAUSE;
          end else if (limit) begin
            state_d      = DONE;
            lap_active_d = 1'b0;
          end else if (evt.lap) begin
            lap_active_d = ~lap_active_q;
            if (!lap_active_q) begin
              lap_d = sw_digits;
            end
          end
        end
        PAUSE: begin
          if (evt.start) begin
            if (limit) begin
              state_d      = DONE;
              lap_active_d = 1'b0;
            end else begin
              state_d = RUN;
            end
          end else if (evt.lap) begin
            lap_active_d = 1'b0;
          end else if (evt.dir) begin
            sw_up_d = ~sw_up_q;
          end
        end
        DONE: begin
          lap_active_d = 1'b0;
        end
      endcase
    end
  end

  // sw_reset comes up asserted so the stopwatch starts from zero after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sw_up_q      <= 1'b1;
      lap_active_q <= 1'b0;
      lap_q        <= BCD_ZERO;
      sw_reset_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      sw_up_q      <= sw_up_d;
      lap_active_q <= lap_active_d;
      lap_q        <= lap_d;
      sw_reset_q   <= sw_reset_d;
    end
  end

  assign sw_enable   = (state_q == RUN) && !limit;
  assign sw_up       = sw_up_q;
  assign sw_reset    = sw_reset_q;
  assign disp_digits = lap_active_q ? lap_q : sw_digits;
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign lap_active  = lap_active_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed reset/debounce/limit sequences, a
// press-level vector table and randomized presses against a reference model.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;

  localparam logic [3:0] B_NONE  = 4'b0000;
  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_CLEAR = 4'b0010;
  localparam logic [3:0] B_DIR   = 4'b0100;
  localparam logic [3:0] B_LAP   = 4'b1000;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] digits;
    logic        run;
    logic        dn;
    logic        up;
    logic        lap;
    logic        en;
    logic [15:0] disp;
    int          rst;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        btn_start;
  logic        btn_clear;
  logic        btn_dir;
  logic        btn_lap;
  logic [15:0] sw_digits;
  logic        sw_enable;
  logic        sw_up;
  logic        sw_reset;
  logic [15:0] disp_digits;
  logic        running;
  logic        done;
  logic        lap_active;

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1, "global timeout");
  end

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DEB), .DB_W(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_start   (btn_start),
    .btn_clear   (btn_clear),
    .btn_dir     (btn_dir),
    .btn_lap     (btn_lap),
    .sw_digits   (sw_digits),
    .sw_enable   (sw_enable),
    .sw_up       (sw_up),
    .sw_reset    (sw_reset),
    .disp_digits (disp_digits),
    .running     (running),
    .done        (done),
    .lap_active  (lap_active)
  );

  // ---------------- behavioural stopwatch ----------------
  logic        model_on;
  logic [15:0] man_digits;
  int          model_cnt;

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    r = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  function automatic int from_bcd(logic [15:0] b);
    return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  always @(posedge clk) begin
    if (!model_on) model_cnt <= from_bcd(man_digits);
    else if (sw_reset) model_cnt <= 0;
    else if (sw_enable) model_cnt <= sw_up ? (model_cnt + 1) % 10000 : (model_cnt + 9999) % 10000;
  end

  always_comb sw_digits = model_on ? to_bcd(model_cnt) : man_digits;

  // ---------------- reference controller model ----------------
  string       m_mode;
  logic        m_up;
  logic        m_lap;
  logic [15:0] m_lapv;

  function automatic logic lim(logic [15:0] d, logic up);
    return (up && d == 16'h9999) || (!up && d == 16'h0000);
  endfunction

  task automatic model_reset();
    m_mode = "idle";
    m_up   = 1'b1;
    m_lap  = 1'b0;
    m_lapv = 16'h0000;
  endtask

  // Digits are applied before the press; a run that hits its limit stops first.
  task automatic model_step(input logic [3:0] mask, input logic [15:0] d, output int exp_rst);
    exp_rst = 0;
    if (m_mode == "run" && lim(d, m_up)) begin
      m_mode = "done";
      m_lap  = 1'b0;
    end
    if (mask[1]) begin
      m_mode  = "idle";
      m_lap   = 1'b0;
      exp_rst = 1;
    end else if (mask[0]) begin
      if (m_mode == "idle" || m_mode == "pause") begin
        if (lim(d, m_up)) begin
          m_mode = "done";
          m_lap  = 1'b0;
        end else begin
          m_mode = "run";
        end
      end else if (m_mode == "run") begin
        m_mode = "pause";
      end
    end else if (mask[3]) begin
      if (m_mode == "run") begin
        if (m_lap) m_lap = 1'b0;
        else begin
          m_lap  = 1'b1;
          m_lapv = d;
        end
      end else if (m_mode == "pause") begin
        m_lap = 1'b0;
      end
    end else if (mask[2]) begin
      if (m_mode == "idle" || m_mode == "pause") m_up = ~m_up;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic er, input logic ed, input logic eu,
                           input logic el, input logic ee, input logic [15:0] edisp,
                           input int erst, input int grst);
    check({tag, "_running"}, running, er);
    check({tag, "_done"}, done, ed);
    check({tag, "_sw_up"}, sw_up, eu);
    check({tag, "_lap_active"}, lap_active, el);
    check({tag, "_sw_enable"}, sw_enable, ee);
    check({tag, "_disp"}, disp_digits, edisp);
    check({tag, "_rst_pulses"}, grst, erst);
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    reset_n   = 1'b0;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    btn_dir   = 1'b0;
    btn_lap   = 1'b0;
    model_on  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Clean press of every button in mask, then a clean release.
  task automatic press(input logic [3:0] mask, output int rst_cnt);
    rst_cnt = 0;
    @(negedge clk);
    {btn_lap, btn_dir, btn_clear, btn_start} = mask;
    repeat (12) begin
      @(negedge clk);
      if (sw_reset) rst_cnt++;
    end
    {btn_lap, btn_dir, btn_clear, btn_start} = 4'b0000;
    repeat (10) begin
      @(negedge clk);
      if (sw_reset) rst_cnt++;
    end
  endtask

  function automatic vec_t mk(logic [3:0] m, logic [15:0] d, int r, int dn, int u, int l,
                              int e, logic [15:0] ds, int rs);
    vec_t v;
    v.mask = m; v.digits = d; v.run = (r != 0); v.dn = (dn != 0); v.up = (u != 0);
    v.lap = (l != 0); v.en = (e != 0); v.disp = ds; v.rst = rs;
    return v;
  endfunction

  function automatic logic [15:0] rand_digits();
    int r;
    r = $urandom_range(0, 5);
    if (r == 0) return 16'h9999;
    if (r == 1) return 16'h0000;
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  vec_t        vecs[22];
  int          rst_got;
  int          rst_exp;
  int          lat;
  logic        saw_run;
  logic        hit;
  logic        saw9;
  logic [3:0]  rmask;
  logic [15:0] rdig;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    man_digits = 16'h0000;
    reset_n    = 1'b1;
    btn_start  = 1'b0;
    btn_clear  = 1'b0;
    btn_dir    = 1'b0;
    btn_lap    = 1'b0;
    model_on   = 1'b0;

    // Reset values and release behaviour
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_sw_reset", sw_reset, 1);
    check_all("rst", 0, 0, 1, 0, 0, 16'h0000, 0, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rel_sw_reset_held", sw_reset, 1);
    @(negedge clk);
    check("rel_sw_reset_drop", sw_reset, 0);
    check("rel_running", running, 0);
    check("rel_enable", sw_enable, 0);

    // Partial count before reset is discarded; held button fires after release
    @(negedge clk);
    btn_dir = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("held_dir_not_early", sw_up, 1);
    repeat (8) @(negedge clk);
    check("held_dir_fired", sw_up, 0);
    btn_dir = 1'b0;
    repeat (10) @(negedge clk);
    check("release_no_event", sw_up, 0);

    // Bouncing start button
    do_reset();
    man_digits = 16'h0100;
    saw_run    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      btn_start = ~btn_start;
      repeat (2) begin
        @(negedge clk);
        if (running) saw_run = 1'b1;
      end
    end
    check("bounce_no_event", saw_run, 0);
    btn_start = 1'b1;
    lat = 0;
    while (!running && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bounce_start_seen", running, 1);
    check("bounce_latency_ok", (lat >= 5 && lat <= 9), 1);
    repeat (20) @(negedge clk);
    check("bounce_single_event", running, 1);
    check("bounce_enable", sw_enable, 1);
    btn_start = 1'b0;
    repeat (10) @(negedge clk);

    // Down-count to zero stops without wrapping
    do_reset();
    man_digits = 16'h0003;
    press(B_DIR, rst_got);
    check("down_dir", sw_up, 0);
    model_on  = 1'b1;
    btn_start = 1'b1;
    hit  = 1'b0;
    saw9 = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (sw_digits == 16'h9999) saw9 = 1'b1;
      if (sw_digits == 16'h0000) begin
        hit = 1'b1;
        check("down_enable_at_zero", sw_enable, 0);
        check("down_not_done_yet", done, 0);
        @(negedge clk);
        check("down_done_next", done, 1);
      end
    end
    check("down_reached_zero", hit, 1);
    repeat (10) begin
      @(negedge clk);
      if (sw_digits == 16'h9999) saw9 = 1'b1;
    end
    check("down_never_9999", saw9, 0);
    btn_start = 1'b0;
    model_on  = 1'b0;

    // Vector table
    vecs[0]  = mk(B_DIR,           16'h0003, 0, 0, 0, 0, 0, 16'h0003, 0);
    vecs[1]  = mk(B_START,         16'h0003, 1, 0, 0, 0, 1, 16'h0003, 0);
    vecs[2]  = mk(B_LAP,           16'h0042, 1, 0, 0, 1, 1, 16'h0042, 0);
    vecs[3]  = mk(B_NONE,          16'h0050, 1, 0, 0, 1, 1, 16'h0042, 0);
    vecs[4]  = mk(B_LAP,           16'h0050, 1, 0, 0, 0, 1, 16'h0050, 0);
    vecs[5]  = mk(B_LAP,           16'h0077, 1, 0, 0, 1, 1, 16'h0077, 0);
    vecs[6]  = mk(B_START,         16'h0077, 0, 0, 0, 1, 0, 16'h0077, 0);
    vecs[7]  = mk(B_LAP,           16'h0080, 0, 0, 0, 0, 0, 16'h0080, 0);
    vecs[8]  = mk(B_DIR,           16'h0080, 0, 0, 1, 0, 0, 16'h0080, 0);
    vecs[9]  = mk(B_START,         16'h9999, 0, 1, 1, 0, 0, 16'h9999, 0);
    vecs[10] = mk(B_DIR,           16'h9999, 0, 1, 1, 0, 0, 16'h9999, 0);
    vecs[11] = mk(B_LAP,           16'h9999, 0, 1, 1, 0, 0, 16'h9999, 0);
    vecs[12] = mk(B_CLEAR,         16'h9999, 0, 0, 1, 0, 0, 16'h9999, 1);
    vecs[13] = mk(B_START,         16'h1234, 1, 0, 1, 0, 1, 16'h1234, 0);
    vecs[14] = mk(B_LAP,           16'h1234, 1, 0, 1, 1, 1, 16'h1234, 0);
    vecs[15] = mk(B_START|B_CLEAR, 16'h5678, 0, 0, 1, 0, 0, 16'h5678, 1);
    vecs[16] = mk(B_START,         16'h0000, 1, 0, 1, 0, 1, 16'h0000, 0);
    vecs[17] = mk(B_NONE,          16'h9999, 0, 1, 1, 0, 0, 16'h9999, 0);
    vecs[18] = mk(B_CLEAR,         16'h0000, 0, 0, 1, 0, 0, 16'h0000, 1);
    vecs[19] = mk(B_START|B_LAP|B_DIR, 16'h0010, 1, 0, 1, 0, 1, 16'h0010, 0);
    vecs[20] = mk(B_LAP|B_DIR,     16'h0010, 1, 0, 1, 1, 1, 16'h0010, 0);
    vecs[21] = mk(B_LAP|B_DIR,     16'h0020, 1, 0, 1, 0, 1, 16'h0020, 0);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      man_digits = vecs[i].digits;
      press(vecs[i].mask, rst_got);
      check_all($sformatf("vec%0d", i), vecs[i].run, vecs[i].dn, vecs[i].up, vecs[i].lap,
                vecs[i].en, vecs[i].disp, vecs[i].rst, rst_got);
    end

    // Randomized presses against the reference model
    man_digits = 16'h0000;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) rmask = 4'($urandom_range(0, 15));
      else rmask = 4'(1 << $urandom_range(0, 3));
      rdig = rand_digits();
      man_digits = rdig;
      model_step(rmask, rdig, rst_exp);
      press(rmask, rst_got);
      check_all($sformatf("rnd%0d", i), m_mode == "run", m_mode == "done", m_up, m_lap,
                (m_mode == "run") && !lim(rdig, m_up), m_lap ? m_lapv : rdig, rst_exp, rst_got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
